// File: rtl/if_id_pkg.sv
// if_id_pkg
//   Shared definitions for the IF/ID pipeline buffer: the decode-side NOP
//   used when the buffer is empty, the stored fetch tuple layout and the
//   buffer depth.
package if_id_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          IF_ID_DEPTH = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [15:0] pc;
    logic [15:0] pc_plus4;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_bubble_counter.sv
// if_id_bubble_counter
//   Saturating 16-bit counter of cycles in which decode had nothing valid to
//   consume. Only built when IF_ID_BUBBLE_CNT_EN is defined.
//
// Ports
//   clk    : system clock, rising edge
//   reset  : synchronous, active-low; clears the count
//   inc    : count this cycle (decode starved)
//   count  : current bubble count, holds at 16'hFFFF
module if_id_bubble_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/if_id_buffer.sv
// if_id_buffer
//   Two-entry FIFO between instruction fetch and decode. Holds
//   {instr, pc, pc_plus4} tuples and delivers them in arrival order. A flush
//   discards everything buffered plus the tuple offered in the same cycle.
//   Optional feature macro: IF_ID_BUBBLE_CNT_EN adds a decode-starved cycle
//   counter on port bubble_count.
//
// Ports
//   clk, reset        : clock and synchronous active-low reset
//   if_instr/pc/pc_plus4, if_valid : fetch tuple in
//   if_ready          : buffer can take a tuple (depends on stored count only)
//   pc_write_zero     : ask fetch to hold PC (inverse of if_ready)
//   flush             : taken branch/jump, empty the buffer
//   id_instr/pc/pc_plus4, id_valid : head tuple out (NOP/zeros when empty)
//   id_ready          : decode consumes the head
//   bubble_count      : starved-cycle count (IF_ID_BUBBLE_CNT_EN only)
module if_id_buffer
  import if_id_pkg::*;
#(
  parameter int DEPTH = IF_ID_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_instr,
  input  logic [15:0] if_pc,
  input  logic [15:0] if_pc_plus4,
  input  logic        if_valid,
  output logic        if_ready,
  output logic        pc_write_zero,
  input  logic        flush,
  output logic [31:0] id_instr,
  output logic [15:0] id_pc,
  output logic [15:0] id_pc_plus4,
  output logic        id_valid,
  input  logic        id_ready
`ifdef IF_ID_BUBBLE_CNT_EN
  ,
  output logic [15:0] bubble_count
`endif
);

  // Pointers are single bits, so only a depth of two is meaningful.
  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  if_id_entry_t mem [0:1];
  logic [1:0]   count;
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_enq;
  logic         do_deq;
  if_id_entry_t head;

  // if_ready is a function of registered count only, so id_ready never
  // reaches fetch combinationally; a full buffer refuses even if decode
  // drains in the same cycle.
  assign if_ready      = (count != FULL_COUNT);
  assign pc_write_zero = ~if_ready;
  assign id_valid      = (count != 2'd0);

  assign do_enq = if_valid && if_ready && !flush;
  assign do_deq = id_valid && id_ready && !flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (do_enq) wr_ptr <= ~wr_ptr;
      if (do_deq) rd_ptr <= ~rd_ptr;
      case ({do_enq, do_deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (reset && do_enq) begin
      mem[wr_ptr] <= '{instr: if_instr, pc: if_pc, pc_plus4: if_pc_plus4};
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    id_instr    = NOP_INSTR;
    id_pc       = 16'h0000;
    id_pc_plus4 = 16'h0000;
    if (id_valid) begin
      id_instr    = head.instr;
      id_pc       = head.pc;
      id_pc_plus4 = head.pc_plus4;
    end
  end

`ifdef IF_ID_BUBBLE_CNT_EN
  if_id_bubble_counter u_bubble_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (~id_valid),
    .count (bubble_count)
  );
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus4;
  logic        if_valid;
  logic        if_ready;
  logic        pc_write_zero;
  logic        flush;
  logic [31:0] id_instr;
  logic [15:0] id_pc;
  logic [15:0] id_pc_plus4;
  logic        id_valid;
  logic        id_ready;
`ifdef IF_ID_BUBBLE_CNT_EN
  logic [15:0] bubble_count;
`endif

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] instr;
    logic [15:0] pc;
    logic [15:0] pc4;
  } tup_t;

  tup_t q[$];
  int   m_bubble = 0;
  bit   pc40_seen = 0;

  always #5 clk = ~clk;

  if_id_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .if_pc_plus4  (if_pc_plus4),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .pc_write_zero(pc_write_zero),
    .flush        (flush),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_pc_plus4  (id_pc_plus4),
    .id_valid     (id_valid),
    .id_ready     (id_ready)
`ifdef IF_ID_BUBBLE_CNT_EN
    ,
    .bubble_count (bubble_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit rst_n, input bit fl, input bit iv,
                       input logic [31:0] ins, input logic [15:0] pc, input bit ir);
    reset       = rst_n;
    flush       = fl;
    if_valid    = iv;
    if_instr    = ins;
    if_pc       = pc;
    if_pc_plus4 = pc + 16'd4;
    id_ready    = ir;
  endtask

  // Reference: a queue of at most two tuples, updated from the rules on the
  // inputs applied before the edge.
  task automatic model_step();
    int sz = q.size();
    if (!reset) begin
      q.delete();
      m_bubble = 0;
    end else begin
      if (sz == 0 && m_bubble < 65535) m_bubble++;
      if (flush) begin
        q.delete();
      end else begin
        if (sz > 0 && id_ready) void'(q.pop_front());
        if (if_valid && sz < 2) q.push_back('{if_instr, if_pc, if_pc_plus4});
      end
    end
  endtask

  task automatic check_all();
    bit v = (q.size() != 0);
    chk("id_valid", 32'(id_valid), 32'(v));
    chk("if_ready", 32'(if_ready), 32'(q.size() < 2));
    chk("pc_write_zero", 32'(pc_write_zero), 32'(q.size() >= 2));
    chk("id_instr", id_instr, v ? q[0].instr : 32'h0000_0013);
    chk("id_pc", 32'(id_pc), v ? 32'(q[0].pc) : 32'h0);
    chk("id_pc_plus4", 32'(id_pc_plus4), v ? 32'(q[0].pc4) : 32'h0);
`ifdef IF_ID_BUBBLE_CNT_EN
    chk("bubble_count", 32'(bubble_count), 32'(m_bubble));
`endif
    if (id_valid === 1'b1 && id_pc === 16'h0040) pc40_seen = 1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    drive(0, 0, 0, 32'h0, 16'h0, 0);
    tick();
    tick();
    chk("reset_if_ready", 32'(if_ready), 32'h1);
    chk("reset_id_instr", id_instr, 32'h0000_0013);

    // idle three cycles after reset
    drive(1, 0, 0, 32'h0, 16'h0, 0);
    repeat (3) tick();
    chk("idle_id_valid", 32'(id_valid), 32'h0);
`ifdef IF_ID_BUBBLE_CNT_EN
    chk("idle_bubble", 32'(bubble_count), 32'd3);
`endif

    // single tuple passes through with one cycle latency
    drive(1, 0, 1, 32'h0050_0093, 16'h0000, 1);
    tick();
    chk("pass_instr", id_instr, 32'h0050_0093);
    chk("pass_valid", 32'(id_valid), 32'h1);
    drive(1, 0, 0, 32'h0, 16'h0, 1);
    tick();
    chk("pass_drained", 32'(id_valid), 32'h0);

    // fill to two, third refused
    drive(1, 0, 1, 32'h1111_0000, 16'h0000, 0); tick();
    drive(1, 0, 1, 32'h1111_0004, 16'h0004, 0); tick();
    chk("full_pwz", 32'(pc_write_zero), 32'h1);
    drive(1, 0, 1, 32'h1111_0008, 16'h0008, 0); tick();
    drive(1, 0, 0, 32'h0, 16'h0, 1); tick();
    chk("drain_pc1", 32'(id_pc), 32'h0004);
    tick();
    chk("drain_empty", 32'(id_valid), 32'h0);

    // steady one-deep streaming
    drive(1, 0, 1, 32'h2222_000C, 16'h000C, 0); tick();
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 1, 32'h2222_0000 + 32'(16'h10 + 4 * i), 16'(16'h10 + 4 * i), 1);
      tick();
      chk("stream_pc", 32'(id_pc), 32'(16'h10 + 4 * i));
      chk("stream_ready", 32'(if_ready), 32'h1);
    end

    // fill, then flush with a tuple offered at 0x0040
    drive(1, 0, 1, 32'h3333_0000, 16'h0030, 0); tick();
    chk("pre_flush_full", 32'(if_ready), 32'h0);
    drive(1, 1, 1, 32'h3333_0040, 16'h0040, 1); tick();
    chk("flush_valid", 32'(id_valid), 32'h0);
    chk("flush_ready", 32'(if_ready), 32'h1);
    drive(1, 0, 0, 32'h0, 16'h0, 0);
    repeat (2) tick();
    chk("flush_pc40_absent", 32'(pc40_seen), 32'h0);

    // reset together with flush while full
    drive(1, 0, 1, 32'h4444_0000, 16'h0050, 0); tick();
    drive(1, 0, 1, 32'h4444_0004, 16'h0054, 0); tick();
    drive(0, 1, 1, 32'h4444_0008, 16'h0058, 1); tick();
    chk("rst_mid_valid", 32'(id_valid), 32'h0);
    chk("rst_mid_pc4", 32'(id_pc_plus4), 32'h0);
`ifdef IF_ID_BUBBLE_CNT_EN
    chk("rst_mid_bubble", 32'(bubble_count), 32'h0);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
            $urandom_range(0, 1), $urandom, 16'($urandom), $urandom_range(0, 1));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 Parameter: DEPTH, 2, number of fetch-packet entries; only value 2 is supported.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  reset, synchronous and active-low.
REQ-004 Port: if_instr  input  32  fetched instruction word.
REQ-005 Port: if_pc  input  16  PC of if_instr.
REQ-006 Port: if_pc_plus4  input  16  if_pc + 4 from fetch.
REQ-007 Port: if_valid  input  1  fetch tuple valid this cycle.
REQ-008 Port: if_ready  output  1  buffer can accept a tuple this cycle.
REQ-009 Port: pc_write_zero  output  1  PC hold request to fetch; equals ~if_ready.
REQ-010 Port: flush  input  1  taken branch/jump; discard all buffered and incoming tuples.
REQ-011 Port: id_instr  output  32  head instruction to decode.
REQ-012 Port: id_pc  output  16  head PC.
REQ-013 Port: id_pc_plus4  output  16  head PC+4.
REQ-014 Port: id_valid  output  1  head entry valid.
REQ-015 Port: id_ready  input  1  decode accepts head this cycle.
REQ-016 Port (only with IF_ID_BUBBLE_CNT_EN): bubble_count  output  16  decode-starved cycle count.

Function
REQ-017 Storage is a 2-entry circular FIFO of {instr, pc, pc_plus4} with 1-bit rd_ptr, 1-bit wr_ptr and 2-bit count (0..2).
REQ-018 Enqueue occurs when if_valid && if_ready && !flush; tuple is written at wr_ptr, wr_ptr toggles.
REQ-019 Dequeue occurs when id_valid && id_ready && !flush; rd_ptr toggles.
REQ-020 if_ready = (count != 2), registered-state only; no combinational path from id_ready to if_ready.
REQ-021 id_valid = (count != 0); id_instr/id_pc/id_pc_plus4 come combinationally from entry rd_ptr.
REQ-022 When id_valid = 0: id_instr = NOP_INSTR (32'h00000013), id_pc = 0, id_pc_plus4 = 0.
REQ-023 Latency: a tuple enqueued in cycle N into an empty buffer appears with id_valid = 1 in cycle N+1.
REQ-024 Simultaneous enqueue and dequeue at count = 1: count stays 1, both pointers toggle, order preserved.
REQ-025 At count = 2, if_valid is ignored (if_ready = 0); the tuple is not written and fetch holds PC via pc_write_zero.
REQ-026 At count = 0, id_ready is ignored; no pointer change.
REQ-027 flush = 1: next cycle count = 0, rd_ptr = wr_ptr = 0, id_valid = 0; same-cycle enqueue and dequeue are both suppressed.
REQ-028 Tuples leave strictly in arrival order; no entry is duplicated or dropped except by flush or reset.

Reset
REQ-029 reset = 0 at a rising edge: count = 0, pointers = 0, id_valid = 0, if_ready = 1, pc_write_zero = 0, id_instr = NOP_INSTR, id_pc = 0, id_pc_plus4 = 0, bubble_count = 0.
REQ-030 Reset takes priority over flush, enqueue and dequeue; entry storage is not reset.
REQ-031 Reset asserted mid-operation discards all buffered tuples identically to REQ-029.

Configuration
REQ-032 Macro IF_ID_BUBBLE_CNT_EN defined: bubble_count increments by 1 each cycle with id_valid = 0 and reset = 1, saturating at 16'hFFFF; flush does not clear it.
REQ-033 Macro undefined: bubble_count port and counter logic are absent; all other behaviour is identical.

Structure
REQ-034 Package if_id_pkg holds NOP_INSTR, typedef if_id_entry_t (packed struct instr[31:0], pc[15:0], pc_plus4[15:0]) and IF_ID_DEPTH = 2.
REQ-035 FIFO control and storage are flat in if_id_buffer; the saturating counter is sub-module if_id_bubble_counter, instantiated only under IF_ID_BUBBLE_CNT_EN.

Verification
REQ-036 Reset, then idle 3 cycles -> id_valid = 0, id_instr = 32'h00000013, if_ready = 1; bubble_count = 3 when enabled.
REQ-037 Enqueue {instr 32'h00500093, pc 16'h0000, pc_plus4 16'h0004} with id_ready = 1 -> next cycle id_valid = 1, id_instr = 32'h00500093, id_pc = 16'h0000; following cycle id_valid = 0.
REQ-038 id_ready = 0, enqueue pc 16'h0000, 16'h0004, 16'h0008 in consecutive cycles -> if_ready = 0 and pc_write_zero = 1 after the second; third not stored; then id_ready = 1 -> id_pc = 16'h0000 then 16'h0004.
REQ-039 count = 1, enqueue and dequeue each cycle for 8 cycles with pc 16'h0010..16'h002C -> id_pc advances by 4 each cycle, count remains 1, no loss.
REQ-040 count = 2, flush = 1 with if_valid = 1 (pc 16'h0040) -> next cycle id_valid = 0, if_ready = 1, pc 16'h0040 never appears on id_pc.
REQ-041 count = 2, reset = 0 for one cycle together with flush = 1 -> all REQ-029 values; bubble_count = 0.
